reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order retirement queue for the Tomasulo core.
- Allocates one tag per dispatched instruction and captures results from the CDB.
- Commits the head entry to the regfile through the rob_regfile_* interface, which carries the regfile's "value ready" / rename-clear handshake.
- On a mispredicted head entry, flushes the regfile rename state, its own entries and the fetcher.

Parameters:
- TAG_W, 4, tag width; tag 0 is reserved as "no producer", so the buffer has 2^TAG_W-1 = 15 entries.
- DATA_W, 32, result / PC width.
- REG_W, 5, architectural register index width.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset
- rdy_in  in  1  global enable; when low, all state holds
- dispatcher_rob_en_in  in  1  allocate request
- dispatcher_rob_rd_in  in  REG_W  destination register; 0 means no writeback
- rob_dispatcher_full_out  out  1  no free entry
- rob_dispatcher_tag_out  out  TAG_W  tag the next allocation receives (tail)
- dispatcher_rob_qj_in, dispatcher_rob_qk_in  in  TAG_W  operand tags to query
- rob_dispatcher_vj_ready_out, rob_dispatcher_vk_ready_out  out  1  queried entry has its result
- rob_dispatcher_vj_out, rob_dispatcher_vk_out  out  DATA_W  queried result
- cdb_rob_en_in  in  1  result broadcast valid
- cdb_rob_tag_in  in  TAG_W  broadcasting tag
- cdb_rob_value_in  in  DATA_W  result value
- cdb_rob_mispredict_in  in  1  branch resolved as mispredicted
- cdb_rob_target_in  in  DATA_W  correct PC
- rob_regfile_en_out  out  1  commit pulse
- rob_regfile_d_out  out  REG_W  committed rd
- rob_regfile_value_out  out  DATA_W  committed value
- rob_regfile_h_out  out  TAG_W  committed tag (regfile clears busy when it matches)
- rob_regfile_rst_out  out  1  clear all rename state
- rob_fetcher_rst_out  out  1  flush pipeline
- rob_fetcher_pc_out  out  DATA_W  redirect PC

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n_in). All entries invalid, head=tail=1, count=0, all registered outputs 0.
  - Reset asserted mid-operation discards everything immediately.
- Tags run 1..15. Pointer increment wraps 15->1 and never yields 0.
- full_out = (count==15), taken from registered state. rob_dispatcher_tag_out = tail.
- Allocate: on an edge with en && !full, the entry at tail becomes valid, not ready, with rd latched; tail advances.
  - Allocation while full is ignored.
  - A commit in the same cycle does not unblock allocation until the next cycle.
- Writeback: on cdb_en to a valid, not-ready entry, latch value, mispredict and target, and set ready.
  - Writeback to tag 0 or to an invalid entry is ignored.
- Commit: at most one per cycle. If the head entry (pre-edge state) is valid and ready, then at that edge:
  - rob_regfile_en_out=1 with d, value and h=head tag, held for exactly one cycle;
  - the entry is invalidated and head advances.
  - Outputs are registered, so a writeback at edge E commits at edge E+1 at the earliest.
- Mispredict commit: a commit whose entry has mispredict set also drives rob_regfile_rst_out=1, rob_fetcher_rst_out=1 and rob_fetcher_pc_out=target, all for the same single cycle.
  - The rd write still occurs, so a JALR link register is written.
  - All entries are invalidated, head=tail=1, count=0.
  - Any allocate or writeback in that same cycle is dropped.
- Simultaneous allocate and commit: count is unchanged.
- Query:
  - Combinational.
  - Tag 0 returns ready=1, value=0.
  - Otherwise returns the stored ready/value.
- rdy_in low: no state change; pulse outputs are driven 0 on the next edge.
- Commit-side invariant: count never exceeds 15.

Optional Feature:
- Macro REORDER_BUFFER_CDB_BYPASS_EN.
  - Defined: a query whose tag equals cdb_rob_tag_in while cdb_rob_en_in is high returns ready=1 and cdb_rob_value_in in the same cycle.
  - Undefined: the query reflects registered state only, so the result is visible one cycle after the broadcast.

Decomposition:
- Shared package / constant.vh holds:
  - tag, data and register widths;
  - the null tag constant 0;
  - entry count 2^TAG_W-1.
- One small sub-module, rob_ptr_inc: combinational wrap-around increment skipping 0, reused for head and tail.

Test Plan:
- Allocate rd=5 (tag 1), CDB tag 1 value 0x1234 -> next edge: rob_regfile_en_out=1, d=5, value=0x1234, h=1 for one cycle.
- Allocate 15 entries -> full_out=1 and a 16th allocate is ignored; commit one entry -> full_out drops, the next allocate gets tag 1 (wrap).
- Tags 1 and 2 allocated, CDB tag 2 first -> no commit; CDB tag 1 -> commits tag 1 then tag 2 on consecutive cycles.
- Tag 1 branch with rd=0, mispredict=1, target 0x100 -> rob_regfile_rst_out=1, rob_fetcher_rst_out=1, pc=0x100; afterwards full_out=0 and the next tag is 1.
- Query qj=3 while CDB tag 3 value 7 -> with the macro defined, ready=1 and value 7 in the same cycle; without it, ready=0.
- Drop rst_n_in mid-stream with 4 entries valid -> outputs 0 immediately; after release, tag_out=1 and full_out=0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, tag constants and entry layout for the reorder buffer.
// Optional same-cycle CDB query bypass lives in reorder_buffer.sv under REORDER_BUFFER_CDB_BYPASS_EN.
package reorder_buffer_pkg;

    localparam int TAG_W     = 4;
    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int ROB_DEPTH = (1 << TAG_W) - 1;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_t;

    // Tag 0 means "no producer"; live tags run 1..ROB_DEPTH.
    localparam tag_t NULL_TAG  = tag_t'(0);
    localparam tag_t FIRST_TAG = tag_t'(1);
    localparam tag_t LAST_TAG  = tag_t'(ROB_DEPTH);

    typedef struct packed {
        logic  valid;
        logic  ready;
        logic  mispredict;
        reg_t  rd;
        data_t value;
        data_t target;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_inc.sv
// Wrap-around tag increment that never produces the null tag (15 -> 1).
module rob_ptr_inc
    import reorder_buffer_pkg::*;
(
    input  tag_t ptr_in,
    output tag_t ptr_out
);

    assign ptr_out = (ptr_in == LAST_TAG) ? FIRST_TAG : ptr_in + tag_t'(1);

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: allocates tags, captures CDB results, commits the head.
// Define REORDER_BUFFER_CDB_BYPASS_EN to let operand queries see a same-cycle CDB broadcast.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              dispatcher_rob_en_in,
    input  logic [REG_W-1:0]  dispatcher_rob_rd_in,
    output logic              rob_dispatcher_full_out,
    output logic [TAG_W-1:0]  rob_dispatcher_tag_out,
    input  logic [TAG_W-1:0]  dispatcher_rob_qj_in,
    input  logic [TAG_W-1:0]  dispatcher_rob_qk_in,
    output logic              rob_dispatcher_vj_ready_out,
    output logic              rob_dispatcher_vk_ready_out,
    output logic [DATA_W-1:0] rob_dispatcher_vj_out,
    output logic [DATA_W-1:0] rob_dispatcher_vk_out,
    input  logic              cdb_rob_en_in,
    input  logic [TAG_W-1:0]  cdb_rob_tag_in,
    input  logic [DATA_W-1:0] cdb_rob_value_in,
    input  logic              cdb_rob_mispredict_in,
    input  logic [DATA_W-1:0] cdb_rob_target_in,
    output logic              rob_regfile_en_out,
    output logic [REG_W-1:0]  rob_regfile_d_out,
    output logic [DATA_W-1:0] rob_regfile_value_out,
    output logic [TAG_W-1:0]  rob_regfile_h_out,
    output logic              rob_regfile_rst_out,
    output logic              rob_fetcher_rst_out,
    output logic [DATA_W-1:0] rob_fetcher_pc_out
);

    rob_entry_t entries_q [ROB_DEPTH+1];
    rob_entry_t entries_d [ROB_DEPTH+1];
    tag_t       head_q, head_d, tail_q, tail_d, head_next, tail_next;
    tag_t       count_q, count_d;
    logic       regfile_en_q, regfile_en_d, regfile_rst_q, regfile_rst_d;
    logic       fetcher_rst_q, fetcher_rst_d;
    reg_t       regfile_d_q, regfile_d_d;
    data_t      regfile_value_q, regfile_value_d, fetcher_pc_q, fetcher_pc_d;
    tag_t       regfile_h_q, regfile_h_d;
    rob_entry_t head_ent;
    logic       full, do_commit, do_flush, do_alloc, do_wb;

    rob_ptr_inc u_head_inc (.ptr_in(head_q), .ptr_out(head_next));
    rob_ptr_inc u_tail_inc (.ptr_in(tail_q), .ptr_out(tail_next));

    assign full                    = (count_q == LAST_TAG);
    assign rob_dispatcher_full_out = full;
    assign rob_dispatcher_tag_out  = tail_q;
    assign rob_regfile_en_out      = regfile_en_q;
    assign rob_regfile_d_out       = regfile_d_q;
    assign rob_regfile_value_out   = regfile_value_q;
    assign rob_regfile_h_out       = regfile_h_q;
    assign rob_regfile_rst_out     = regfile_rst_q;
    assign rob_fetcher_rst_out     = fetcher_rst_q;
    assign rob_fetcher_pc_out      = fetcher_pc_q;

    always_comb begin
        head_ent  = entries_q[head_q];
        do_commit = rdy_in && head_ent.valid && head_ent.ready;
        do_flush  = do_commit && head_ent.mispredict;
        // Fullness comes from registered count, so a same-cycle commit cannot free a slot.
        do_alloc  = rdy_in && dispatcher_rob_en_in && !full && !do_flush;
        do_wb     = rdy_in && cdb_rob_en_in && (cdb_rob_tag_in != NULL_TAG) && !do_flush
                    && entries_q[cdb_rob_tag_in].valid && !entries_q[cdb_rob_tag_in].ready;

        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + tag_t'(do_alloc) - tag_t'(do_commit);

        if (do_wb) begin
            entries_d[cdb_rob_tag_in].ready      = 1'b1;
            entries_d[cdb_rob_tag_in].value      = cdb_rob_value_in;
            entries_d[cdb_rob_tag_in].mispredict = cdb_rob_mispredict_in;
            entries_d[cdb_rob_tag_in].target     = cdb_rob_target_in;
        end
        if (do_alloc) begin
            entries_d[tail_q]       = '0;
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].rd    = dispatcher_rob_rd_in;
            tail_d                  = tail_next;
        end
        if (do_commit) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_next;
        end
        if (do_flush) begin
            for (int i = 0; i <= ROB_DEPTH; i++) entries_d[i].valid = 1'b0;
            head_d  = FIRST_TAG;
            tail_d  = FIRST_TAG;
            count_d = '0;
        end

        regfile_en_d    = do_commit;
        regfile_rst_d   = do_flush;
        fetcher_rst_d   = do_flush;
        regfile_d_d     = do_commit ? head_ent.rd : regfile_d_q;
        regfile_value_d = do_commit ? head_ent.value : regfile_value_q;
        regfile_h_d     = do_commit ? head_q : regfile_h_q;
        fetcher_pc_d    = do_flush ? head_ent.target : fetcher_pc_q;
    end

    always_comb begin
        rob_dispatcher_vj_ready_out = 1'b1;
        rob_dispatcher_vj_out       = '0;
        rob_dispatcher_vk_ready_out = 1'b1;
        rob_dispatcher_vk_out       = '0;
        if (dispatcher_rob_qj_in != NULL_TAG) begin
            rob_dispatcher_vj_ready_out = entries_q[dispatcher_rob_qj_in].ready;
            rob_dispatcher_vj_out       = entries_q[dispatcher_rob_qj_in].value;
`ifdef REORDER_BUFFER_CDB_BYPASS_EN
            if (cdb_rob_en_in && (cdb_rob_tag_in == dispatcher_rob_qj_in)) begin
                rob_dispatcher_vj_ready_out = 1'b1;
                rob_dispatcher_vj_out       = cdb_rob_value_in;
            end
`endif
        end
        if (dispatcher_rob_qk_in != NULL_TAG) begin
            rob_dispatcher_vk_ready_out = entries_q[dispatcher_rob_qk_in].ready;
            rob_dispatcher_vk_out       = entries_q[dispatcher_rob_qk_in].value;
`ifdef REORDER_BUFFER_CDB_BYPASS_EN
            if (cdb_rob_en_in && (cdb_rob_tag_in == dispatcher_rob_qk_in)) begin
                rob_dispatcher_vk_ready_out = 1'b1;
                rob_dispatcher_vk_out       = cdb_rob_value_in;
            end
`endif
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i <= ROB_DEPTH; i++) entries_q[i] <= '0;
            head_q          <= FIRST_TAG;
            tail_q          <= FIRST_TAG;
            count_q         <= '0;
            regfile_en_q    <= 1'b0;
            regfile_rst_q   <= 1'b0;
            fetcher_rst_q   <= 1'b0;
            regfile_d_q     <= '0;
            regfile_value_q <= '0;
            regfile_h_q     <= '0;
            fetcher_pc_q    <= '0;
        end else begin
            for (int i = 0; i <= ROB_DEPTH; i++) entries_q[i] <= entries_d[i];
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            regfile_en_q    <= regfile_en_d;
            regfile_rst_q   <= regfile_rst_d;
            fetcher_rst_q   <= fetcher_rst_d;
            regfile_d_q     <= regfile_d_d;
            regfile_value_q <= regfile_value_d;
            regfile_h_q     <= regfile_h_d;
            fetcher_pc_q    <= fetcher_pc_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic against a queue-based model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in;
    logic        disp_en;
    logic [4:0]  disp_rd;
    logic        full_out;
    logic [3:0]  tag_out, qj, qk, cdb_tag;
    logic        vj_ready, vk_ready, cdb_en, cdb_mp;
    logic [31:0] vj, vk, cdb_value, cdb_target;
    logic        rf_en, rf_rst, f_rst;
    logic [4:0]  rf_d;
    logic [31:0] rf_value, f_pc;
    logic [3:0]  rf_h;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .dispatcher_rob_en_in(disp_en), .dispatcher_rob_rd_in(disp_rd),
        .rob_dispatcher_full_out(full_out), .rob_dispatcher_tag_out(tag_out),
        .dispatcher_rob_qj_in(qj), .dispatcher_rob_qk_in(qk),
        .rob_dispatcher_vj_ready_out(vj_ready), .rob_dispatcher_vk_ready_out(vk_ready),
        .rob_dispatcher_vj_out(vj), .rob_dispatcher_vk_out(vk),
        .cdb_rob_en_in(cdb_en), .cdb_rob_tag_in(cdb_tag), .cdb_rob_value_in(cdb_value),
        .cdb_rob_mispredict_in(cdb_mp), .cdb_rob_target_in(cdb_target),
        .rob_regfile_en_out(rf_en), .rob_regfile_d_out(rf_d), .rob_regfile_value_out(rf_value),
        .rob_regfile_h_out(rf_h), .rob_regfile_rst_out(rf_rst),
        .rob_fetcher_rst_out(f_rst), .rob_fetcher_pc_out(f_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] value;
        bit          mp;
        logic [31:0] tgt;
    } rec_t;

    rec_t        mq[$];
    int          next_tag;
    bit          e_en, e_rst;
    logic [4:0]  e_d;
    logic [31:0] e_val, e_pc;
    int          e_h;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(string nm, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_tag = 1;
        e_en = 0; e_rst = 0;
    endtask

    task automatic model_edge();
        bit commit;
        int pre_size;
        e_en = 0; e_rst = 0;
        if (!rdy_in) return;
        pre_size = mq.size();
        commit = (pre_size > 0) && mq[0].done;
        if (commit) begin
            e_en = 1; e_d = mq[0].rd; e_val = mq[0].value; e_h = mq[0].tag;
            if (mq[0].mp) begin
                e_rst = 1; e_pc = mq[0].tgt;
                mq.delete();
                next_tag = 1;
                return;
            end
        end
        if (cdb_en)
            foreach (mq[i])
                if (mq[i].tag == int'(cdb_tag) && !mq[i].done) begin
                    mq[i].done = 1; mq[i].value = cdb_value;
                    mq[i].mp = cdb_mp; mq[i].tgt = cdb_target;
                end
        if (disp_en && pre_size < ROB_DEPTH) begin
            mq.push_back('{tag: next_tag, rd: disp_rd, done: 0, value: 0, mp: 0, tgt: 0});
            next_tag = (next_tag == ROB_DEPTH) ? 1 : next_tag + 1;
        end
        if (commit) void'(mq.pop_front());
    endtask

    // Expected query result; known=0 when the tag names no live entry (stale storage is not modelled).
    task automatic query_exp(int t, output bit known, output bit r, output logic [31:0] v);
        known = 0; r = 0; v = 0;
        if (t == 0) begin known = 1; r = 1; return; end
`ifdef REORDER_BUFFER_CDB_BYPASS_EN
        if (cdb_en && int'(cdb_tag) == t) begin known = 1; r = 1; v = cdb_value; return; end
`endif
        foreach (mq[i])
            if (mq[i].tag == t) begin known = 1; r = mq[i].done; v = mq[i].value; end
    endtask

    task automatic check_queries();
        bit k, r; logic [31:0] v;
        query_exp(int'(qj), k, r, v);
        if (k) begin
            chk("vj_ready", 32'(vj_ready), 32'(r));
            if (r) chk("vj_value", vj, v);
        end
        query_exp(int'(qk), k, r, v);
        if (k) begin
            chk("vk_ready", 32'(vk_ready), 32'(r));
            if (r) chk("vk_value", vk, v);
        end
    endtask

    task automatic check_outputs();
        chk("commit_en", 32'(rf_en), 32'(e_en));
        if (e_en) begin
            chk("commit_d", 32'(rf_d), 32'(e_d));
            chk("commit_value", rf_value, e_val);
            chk("commit_h", 32'(rf_h), 32'(e_h));
        end
        chk("regfile_rst", 32'(rf_rst), 32'(e_rst));
        chk("fetcher_rst", 32'(f_rst), 32'(e_rst));
        if (e_rst) chk("fetcher_pc", f_pc, e_pc);
        chk("full", 32'(full_out), 32'(mq.size() == ROB_DEPTH));
        chk("tag_out", 32'(tag_out), 32'(next_tag));
    endtask

    task automatic step();
        #1;
        check_queries();
        @(posedge clk_in);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        rdy_in = 1; disp_en = 0; disp_rd = 0; cdb_en = 0; cdb_tag = 0;
        cdb_value = 0; cdb_mp = 0; cdb_target = 0; qj = 0; qk = 0;
    endtask

    task automatic alloc(logic [4:0] rd);
        idle(); disp_en = 1; disp_rd = rd; step();
    endtask

    task automatic wb(int t, logic [31:0] v, bit mp, logic [31:0] tgt);
        idle(); cdb_en = 1; cdb_tag = 4'(t); cdb_value = v; cdb_mp = mp; cdb_target = tgt; step();
    endtask

    initial begin
        idle();
        rst_n_in = 0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check_outputs();
        @(negedge clk_in);
        rst_n_in = 1;

        // Single commit: rd=5, value 0x1234, tag 1.
        alloc(5'd5);
        wb(1, 32'h1234, 0, 0);
        idle(); step();
        chk("t1_en", 32'(rf_en), 32'd1);
        chk("t1_d", 32'(rf_d), 32'd5);
        chk("t1_value", rf_value, 32'h1234);
        chk("t1_h", 32'(rf_h), 32'd1);
        idle(); step();
        chk("t1_pulse_once", 32'(rf_en), 32'd0);

        // Out-of-order completion, in-order commit (tags 2 and 3).
        alloc(5'd7); alloc(5'd8);
        wb(3, 32'hBBBB, 0, 0);
        idle(); step();
        wb(2, 32'hAAAA, 0, 0);
        idle(); step();
        chk("ooo_first_h", 32'(rf_h), 32'd2);
        idle(); step();
        chk("ooo_second_h", 32'(rf_h), 32'd3);

        // Mispredicted branch at head flushes everything.
        alloc(5'd0);
        wb(4, 32'h44, 1, 32'h100);
        idle(); step();
        chk("mp_regfile_rst", 32'(rf_rst), 32'd1);
        chk("mp_pc", f_pc, 32'h100);
        chk("mp_tag_after", 32'(tag_out), 32'd1);
        chk("mp_full_after", 32'(full_out), 32'd0);

        // Fill to 15, overflow ignored, commit does not unblock same cycle, wrap to tag 1.
        for (int i = 0; i < ROB_DEPTH; i++) alloc(5'(i + 1));
        chk("fill_full", 32'(full_out), 32'd1);
        alloc(5'd30);
        chk("overflow_tag", 32'(tag_out), 32'd1);
        wb(1, 32'h11, 0, 0);
        alloc(5'd29);
        chk("commit_no_unblock", 32'(full_out), 32'd0);
        alloc(5'd28);
        chk("wrap_full_again", 32'(full_out), 32'd1);

        // Reset mid-stream while a commit pulse is showing.
        wb(2, 32'h22, 0, 0);
        idle(); step();
        rst_n_in = 0;
        model_reset();
        #1;
        chk("async_rst_en", 32'(rf_en), 32'd0);
        chk("async_rst_tag", 32'(tag_out), 32'd1);
        chk("async_rst_full", 32'(full_out), 32'd0);
        @(negedge clk_in);
        rst_n_in = 1;

        // Query vs same-cycle broadcast.
        alloc(5'd1); alloc(5'd2); alloc(5'd3);
        idle(); cdb_en = 1; cdb_tag = 4'd3; cdb_value = 32'd7; qj = 4'd3;
        #1;
`ifdef REORDER_BUFFER_CDB_BYPASS_EN
        chk("bypass_ready", 32'(vj_ready), 32'd1);
        chk("bypass_value", vj, 32'd7);
`else
        chk("nobypass_ready", 32'(vj_ready), 32'd0);
`endif
        step();
        idle(); qj = 4'd3; step();
        chk("query_after_wb", vj, 32'd7);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            rdy_in  = ($urandom % 8) != 0;
            disp_en = $urandom % 2;
            disp_rd = 5'($urandom);
            cdb_en  = $urandom % 2;
            if (mq.size() > 0 && ($urandom % 4) != 0)
                cdb_tag = 4'(mq[$urandom % mq.size()].tag);
            else
                cdb_tag = 4'($urandom);
            cdb_value  = $urandom;
            cdb_mp     = ($urandom % 16) == 0;
            cdb_target = $urandom;
            qj = 4'($urandom);
            qk = (mq.size() > 0) ? 4'(mq[$urandom % mq.size()].tag) : 4'd0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
